// File: rtl/master_axi_4_lite_duplex.sv
// master_axi_4_lite_duplex: AXI4-lite master with independent write and read request channels; define AXI_LITE_TIMEOUT_EN for a per-channel watchdog.
// Latency: 3 cycles from request acceptance to rsp pulse with an always-ready slave; one transaction per 4 cycles per channel.
// Backpressure: wreq_ready/rreq_ready are low while the channel is busy and during its rsp pulse cycle.
module master_axi_4_lite_duplex #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic                          wreq_valid,
    output logic                          wreq_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     wreq_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     wreq_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wreq_strb,
    output logic                          wrsp_valid,
    output logic [1:0]                    wrsp_resp,
    input  logic                          rreq_valid,
    output logic                          rreq_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     rreq_addr,
    output logic                          rrsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]     rrsp_data,
    output logic [1:0]                    rrsp_resp,
    output logic [AXI_ADDR_WIDTH-1:0]     AXI_AWADDR,
    output logic [2:0]                    AXI_AWPROT,
    output logic                          AXI_AWVALID,
    input  logic                          AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
    output logic                          AXI_WVALID,
    input  logic                          AXI_WREADY,
    input  logic [1:0]                    AXI_BRESP,
    input  logic                          AXI_BVALID,
    output logic                          AXI_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]     AXI_ARADDR,
    output logic [2:0]                    AXI_ARPROT,
    output logic                          AXI_ARVALID,
    input  logic                          AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     AXI_RDATA,
    input  logic [1:0]                    AXI_RRESP,
    input  logic                          AXI_RVALID,
    output logic                          AXI_RREADY
);

    if (!(AXI_DATA_WIDTH == 32 || AXI_DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("master_axi_4_lite_duplex: unsupported parameter value");
    end

    typedef enum logic [2:0] {W_IDLE, W_AW_W, W_W, W_AW, W_B} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb_q;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr_q;
    logic                        w_expired;
    logic                        r_expired;

    assign AXI_AWADDR = aw_addr_q;
    assign AXI_WDATA  = w_data_q;
    assign AXI_WSTRB  = w_strb_q;
    assign AXI_ARADDR = ar_addr_q;
    assign AXI_AWPROT = 3'b000;
    assign AXI_ARPROT = 3'b000;

`ifdef AXI_LITE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] r_cnt;

    // Counters sit at zero while idle, so each transaction starts counting from zero.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET || w_state == W_IDLE) w_cnt <= '0;
        else                                 w_cnt <= w_cnt + CNT_W'(1);
        if (AXI_ARESET || r_state == R_IDLE) r_cnt <= '0;
        else                                 r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_expired = (w_state != W_IDLE) && (w_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign r_expired = (r_state != R_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expired = 1'b0;
    assign r_expired = 1'b0;
`endif

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            w_state     <= W_IDLE;
            wreq_ready  <= 1'b1;
            AXI_AWVALID <= 1'b0;
            AXI_WVALID  <= 1'b0;
            AXI_BREADY  <= 1'b0;
            wrsp_valid  <= 1'b0;
            wrsp_resp   <= 2'b00;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
        end else begin
            wrsp_valid <= 1'b0;
            if (w_expired) begin
                w_state     <= W_IDLE;
                AXI_AWVALID <= 1'b0;
                AXI_WVALID  <= 1'b0;
                AXI_BREADY  <= 1'b0;
                wrsp_valid  <= 1'b1;
                wrsp_resp   <= 2'b11;
            end else begin
                case (w_state)
                    // ready is held low for the rsp pulse cycle and re-opens the cycle after
                    W_IDLE: begin
                        wreq_ready <= 1'b1;
                        if (wreq_valid && wreq_ready) begin
                            wreq_ready  <= 1'b0;
                            aw_addr_q   <= wreq_addr;
                            w_data_q    <= wreq_data;
                            w_strb_q    <= wreq_strb;
                            AXI_AWVALID <= 1'b1;
                            AXI_WVALID  <= 1'b1;
                            w_state     <= W_AW_W;
                        end
                    end
                    W_AW_W: begin
                        if (AXI_AWREADY) AXI_AWVALID <= 1'b0;
                        if (AXI_WREADY)  AXI_WVALID  <= 1'b0;
                        if (AXI_AWREADY && AXI_WREADY) begin
                            AXI_BREADY <= 1'b1;
                            w_state    <= W_B;
                        end else if (AXI_AWREADY) begin
                            w_state <= W_W;
                        end else if (AXI_WREADY) begin
                            w_state <= W_AW;
                        end
                    end
                    W_W: begin
                        if (AXI_WREADY) begin
                            AXI_WVALID <= 1'b0;
                            AXI_BREADY <= 1'b1;
                            w_state    <= W_B;
                        end
                    end
                    W_AW: begin
                        if (AXI_AWREADY) begin
                            AXI_AWVALID <= 1'b0;
                            AXI_BREADY  <= 1'b1;
                            w_state     <= W_B;
                        end
                    end
                    W_B: begin
                        if (AXI_BVALID) begin
                            AXI_BREADY <= 1'b0;
                            wrsp_valid <= 1'b1;
                            wrsp_resp  <= AXI_BRESP;
                            w_state    <= W_IDLE;
                        end
                    end
                    default: w_state <= W_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            r_state     <= R_IDLE;
            rreq_ready  <= 1'b1;
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b0;
            rrsp_valid  <= 1'b0;
            rrsp_resp   <= 2'b00;
            rrsp_data   <= '0;
            ar_addr_q   <= '0;
        end else begin
            rrsp_valid <= 1'b0;
            if (r_expired) begin
                r_state     <= R_IDLE;
                AXI_ARVALID <= 1'b0;
                AXI_RREADY  <= 1'b0;
                rrsp_valid  <= 1'b1;
                rrsp_resp   <= 2'b11;
            end else begin
                case (r_state)
                    R_IDLE: begin
                        rreq_ready <= 1'b1;
                        if (rreq_valid && rreq_ready) begin
                            rreq_ready  <= 1'b0;
                            ar_addr_q   <= rreq_addr;
                            AXI_ARVALID <= 1'b1;
                            r_state     <= R_AR;
                        end
                    end
                    R_AR: begin
                        if (AXI_ARREADY) begin
                            AXI_ARVALID <= 1'b0;
                            AXI_RREADY  <= 1'b1;
                            r_state     <= R_R;
                        end
                    end
                    R_R: begin
                        if (AXI_RVALID) begin
                            AXI_RREADY <= 1'b0;
                            rrsp_valid <= 1'b1;
                            rrsp_data  <= AXI_RDATA;
                            rrsp_resp  <= AXI_RRESP;
                            r_state    <= R_IDLE;
                        end
                    end
                    default: r_state <= R_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/master_axi_4_lite_duplex.md
MASTER_AXI_4_LITE_DUPLEX -- requirements
Module: master_axi_4_lite_duplex

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64: data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit per channel; only used under REQ-030.
REQ-004 SHALL have ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESET  in  1  reset, synchronous, active-high.
- wreq_valid/wreq_ready  in/out  1/1  write request handshake.
- wreq_addr/wreq_data/wreq_strb  in  ADDR/DATA/DATA/8  write request payload.
- wrsp_valid  out  1  one-cycle write-done pulse.
- wrsp_resp  out  2  BRESP, or 2'b11 on timeout.
- rreq_valid/rreq_ready  in/out  1/1  read request handshake.
- rreq_addr  in  ADDR  read address.
- rrsp_valid  out  1  one-cycle read-done pulse.
- rrsp_data  out  DATA  read data.
- rrsp_resp  out  2  RRESP, or 2'b11 on timeout.
- AXI_AW*, AXI_W*, AXI_B*, AXI_AR*, AXI_R*  standard AXI4-lite master signals; AWPROT/ARPROT tied 3'b000; WSTRB width DATA/8.

Function
REQ-005 SHALL run write and read channels as two independent FSMs that operate concurrently; no arbitration between them.
REQ-006 SHALL assert wreq_ready only in W_IDLE; a request is accepted when wreq_valid && wreq_ready.
REQ-007 SHALL register addr/data/strb on acceptance; AXI_AWADDR/WDATA/WSTRB SHALL drive registered values, stable until the handshake completes.
REQ-008 Write FSM states: W_IDLE, W_AW_W (AWVALID=WVALID=1), W_W (AW done), W_AW (W done), W_B.
REQ-009 W_IDLE -> W_AW_W on acceptance; the next cycle drives AWVALID and WVALID high.
REQ-010 In W_AW_W: AWREADY&&WREADY -> W_B; AWREADY only -> W_W; WREADY only -> W_AW; each VALID drops the cycle after its handshake.
REQ-011 W_W -> W_B on WREADY; W_AW -> W_B on AWREADY.
REQ-012 BREADY SHALL be high only in W_B; on BVALID: pulse wrsp_valid one cycle, set wrsp_resp=BRESP, return to W_IDLE.
REQ-013 Read FSM states: R_IDLE (rreq_ready=1), R_AR (ARVALID=1), R_R (RREADY=1).
REQ-014 R_IDLE -> R_AR on acceptance, with the address registered; R_AR -> R_R on ARREADY.
REQ-015 R_R -> R_IDLE on RVALID; pulse rrsp_valid one cycle; rrsp_data=RDATA and rrsp_resp=RRESP, both held until the next read completion.
REQ-016 Minimum latency: acceptance to rsp pulse SHALL be 3 cycles when the slave is ready immediately.
REQ-017 VALID SHALL never deassert before its READY; RREADY/BREADY SHALL be low outside R_R/W_B.
REQ-018 A new request SHALL be accepted no earlier than the cycle after the previous rsp pulse; back-to-back throughput is one transaction per 4 cycles per channel.
REQ-019 wrsp_resp/rrsp_resp are 2 bits; SLVERR/DECERR SHALL be passed through unmodified and SHALL NOT alter FSM flow.

Reset
REQ-020 On AXI_ARESET: both FSMs idle; all AXI VALID/READY outputs 0; wrsp_valid=rrsp_valid=0; resp=2'b00; rrsp_data=0; captured regs=0; timeout counters=0.
REQ-021 Reset mid-transaction SHALL abort without a rsp pulse; wreq_ready and rreq_ready SHALL be 1 the first cycle after reset deasserts.

Configuration
REQ-030 Macro AXI_LITE_TIMEOUT_EN: when defined, each channel SHALL have a counter cleared on entering a non-idle state and incremented every non-idle cycle; on reaching TIMEOUT_CYCLES the channel SHALL drop all its VALID/READY, pulse rsp with resp=2'b11, and return to idle.
REQ-031 Without AXI_LITE_TIMEOUT_EN: no counters; channels wait indefinitely; resp 2'b11 only when the slave returns it.

Verification
REQ-040 Write 0x8000_0010, data 0x1122334455667788, strb 0xFF, slave ready immediately, BRESP=0 -> wrsp_valid pulses 3 cycles after acceptance, resp 2'b00.
REQ-041 AWREADY 2 cycles before WREADY -> path W_AW_W->W_W->W_B; AWVALID low after its handshake; WVALID held until WREADY.
REQ-042 Concurrent read 0x8000_0000 and write 0x8000_0008, both accepted the same cycle -> both complete; RDATA 0xDEADBEEF returned on rrsp_data; no cross-channel stall.
REQ-043 Slave returns RRESP=2'b10 -> rrsp_resp=2'b10, FSM back in R_IDLE, next read accepted.
REQ-044 With AXI_LITE_TIMEOUT_EN and TIMEOUT_CYCLES=16, ARREADY never asserted -> ARVALID drops and rrsp_valid pulses with resp 2'b11 after 16 non-idle cycles.
REQ-045 Assert AXI_ARESET while in W_B -> BREADY=0 and no wrsp pulse; wreq_ready=1 the cycle after reset release.
